mips_trace_buffer: RTL and testbench

- Downstream consumer of the single-cycle MIPS core's per-cycle status outputs (PC, instruction, writeback, store and control flags).
- Captures one retirement record per enabled clock into a record FIFO and drains it as a 32-bit word stream, header first, for a debug UART/host.
- Sits beside the core in the top level and never back-pressures it. Records that do not fit are dropped and counted.

---
 rtl/mips_trace_buffer.sv | 132 +++++++++++++
 tb/tb_mips_trace_buffer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_trace_buffer.sv
// Retirement trace buffer for the single-cycle MIPS core: captures one record
// per retired instruction into a FIFO and streams each record as four 32-bit words.
module mips_trace_buffer #(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cap_en,
   input  logic [3:0]        cap_mask,
   input  logic [31:0]       pc_in,
   input  logic [31:0]       instr_in,
   input  logic [31:0]       write_data_in,
   input  logic [31:0]       store_data_in,
   input  logic [31:0]       alu_result_in,
   input  logic [4:0]        write_reg_in,
   input  logic              reg_write,
   input  logic              mem_write,
   input  logic              jump,
   input  logic              jal,
   input  logic              jr,
   input  logic              branch,
   input  logic              zero,
   output logic [31:0]       out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic [ADDR_W:0]   count,
   output logic [15:0]       drop_count,
   output logic              overflow
);

   // Stream handshake: a word transfers on a rising edge where out_valid and
   // out_ready are both high; out_data/out_last stay put while the sink stalls.
   typedef enum logic [1:0] {W0, W1, W2, W3} word_t;

   word_t               state, state_next;
   logic [31:0]         mem_w0 [DEPTH];
   logic [31:0]         mem_w1 [DEPTH];
   logic [31:0]         mem_w2 [DEPTH];
   logic [31:0]         mem_w3 [DEPTH];
   logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
   logic [ADDR_W:0]     count_q;
   logic [15:0]         seq;
   logic [15:0]         drop_q;
   logic                overflow_q;
   logic [3:0]          flags;
   logic                retire, qualify, full, accept, pop, push, drop;
   logic [31:0]         w3_sel;

   assign flags   = {reg_write, mem_write, jump | jal | jr, branch & zero};
   assign retire  = cap_en & ~reset;
   assign qualify = retire & ((cap_mask == 4'd0) | (|(flags & cap_mask)));
   assign full    = (count_q == (ADDR_W+1)'(DEPTH));
   assign accept  = out_valid & out_ready;
   assign pop     = accept & (state == W3);
   // A full FIFO still takes the record when the head leaves in the same cycle.
   assign push    = qualify & (~full | pop);
   assign drop    = qualify & full & ~pop;
   assign w3_sel  = reg_write ? write_data_in :
                    mem_write ? store_data_in : alu_result_in;

   assign out_valid  = (count_q != '0);
   assign count      = count_q;
   assign drop_count = drop_q;
   assign overflow   = overflow_q;

   always_ff @(posedge clk) begin
      if (reset) state <= W0;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      out_data   = 32'd0;
      out_last   = 1'b0;
      if (out_valid) begin
         case (state)
            W0: out_data = mem_w0[rd_ptr];
            W1: out_data = mem_w1[rd_ptr];
            W2: out_data = mem_w2[rd_ptr];
            W3: begin
               out_data = mem_w3[rd_ptr];
               out_last = 1'b1;
            end
            default: out_data = 32'd0;
         endcase
      end
      if (accept) begin
         case (state)
            W0:      state_next = W1;
            W1:      state_next = W2;
            W2:      state_next = W3;
            default: state_next = W0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_w0[wr_ptr] <= {4'hA, flags, 3'b000, write_reg_in, seq};
         mem_w1[wr_ptr] <= pc_in;
         mem_w2[wr_ptr] <= instr_in;
         mem_w3[wr_ptr] <= w3_sel;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_q    <= '0;
         seq        <= 16'd0;
         drop_q     <= 16'd0;
         overflow_q <= 1'b0;
      end else begin
         if (retire) seq <= seq + 16'd1;
         if (push)   wr_ptr <= wr_ptr + 1'b1;
         if (pop)    rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         if (drop) begin
            overflow_q <= 1'b1;
            if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Directed self-checking bench for mips_trace_buffer: capture, filtering,
// overflow/drop, full-FIFO pop+push, mid-record reset and counter wrap.
module tb_mips_trace_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic        cap_en;
   logic [3:0]  cap_mask;
   logic [31:0] pc_in, instr_in, write_data_in, store_data_in, alu_result_in;
   logic [4:0]  write_reg_in;
   logic        reg_write, mem_write, jump, jal, jr, branch, zero;
   logic [31:0] out_data;
   logic        out_valid, out_ready, out_last;
   logic [3:0]  count;
   logic [15:0] drop_count;
   logic        overflow;

   int n_tests = 0;
   int n_fail  = 0;

   mips_trace_buffer #(.DEPTH(8), .ADDR_W(3)) dut (
      .clk(clk), .reset(reset), .cap_en(cap_en), .cap_mask(cap_mask),
      .pc_in(pc_in), .instr_in(instr_in), .write_data_in(write_data_in),
      .store_data_in(store_data_in), .alu_result_in(alu_result_in),
      .write_reg_in(write_reg_in), .reg_write(reg_write), .mem_write(mem_write),
      .jump(jump), .jal(jal), .jr(jr), .branch(branch), .zero(zero),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .count(count), .drop_count(drop_count),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // fl = {reg_write, mem_write, jump, branch&zero}
   task automatic set_rec(input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] wd,
                          input logic [31:0] sd, input logic [31:0] alu, input logic [4:0] wr,
                          input logic [3:0] fl);
      cap_en        = 1'b1;
      pc_in         = pc;
      instr_in      = ins;
      write_data_in = wd;
      store_data_in = sd;
      alu_result_in = alu;
      write_reg_in  = wr;
      reg_write     = fl[3];
      mem_write     = fl[2];
      jump          = fl[1];
      jal           = 1'b0;
      jr            = 1'b0;
      branch        = fl[0];
      zero          = fl[0];
   endtask

   task automatic idle();
      cap_en = 1'b0;
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      cap_en = 1'b0;
      tick();
      reset  = 1'b0;
   endtask

   // Expects out_ready=1 from the caller; waits (bounded) for each word.
   task automatic expect_record(input string tag, input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] w2, input logic [31:0] w3);
      logic [31:0] w [4];
      w = '{w0, w1, w2, w3};
      for (int k = 0; k < 4; k++) begin
         int t;
         t = 0;
         @(negedge clk);
         while (!(out_valid && out_ready) && t < 20) begin
            t++;
            @(negedge clk);
         end
         check($sformatf("%s_valid%0d", tag, k), out_valid, 1);
         check($sformatf("%s_w%0d", tag, k), out_data, w[k]);
         check($sformatf("%s_last%0d", tag, k), out_last, (k == 3) ? 1 : 0);
         tick();
      end
   endtask

   initial begin
      reset = 1'b1; cap_en = 1'b0; cap_mask = 4'd0; out_ready = 1'b0;
      pc_in = '0; instr_in = '0; write_data_in = '0; store_data_in = '0;
      alu_result_in = '0; write_reg_in = '0; reg_write = 0; mem_write = 0;
      jump = 0; jal = 0; jr = 0; branch = 0; zero = 0;
      tick();
      tick();
      @(negedge clk);
      check("rst_valid", out_valid, 0);
      check("rst_last", out_last, 0);
      check("rst_data", out_data, 0);
      check("rst_count", count, 0);
      check("rst_drop", drop_count, 0);
      check("rst_ovf", overflow, 0);

      // Single reg-write record, sink always ready.
      tick();
      reset = 1'b0;
      set_rec(32'h0000_0004, 32'h2008_0005, 32'h5, 32'h0, 32'h0, 5'd8, 4'b1000);
      out_ready = 1'b1;
      tick();
      idle();
      expect_record("t1", 32'hA808_0000, 32'h0000_0004, 32'h2008_0005, 32'h0000_0005);
      @(negedge clk);
      check("t1_count", count, 0);
      check("t1_valid_after", out_valid, 0);

      // Store record passes the mask, plain ALU cycle is filtered but still ages seq.
      tick();
      out_ready = 1'b0;
      cap_mask  = 4'b0100;
      set_rec(32'h10, 32'hAC0A_0000, 32'h1111, 32'hDEAD_BEEF, 32'h2222, 5'd0, 4'b0100);
      tick();
      set_rec(32'h14, 32'h0123_4567, 32'h3, 32'h4, 32'h5, 5'd0, 4'b0000);
      tick();
      set_rec(32'h18, 32'hAC0B_0004, 32'h6, 32'h0BAD_F00D, 32'h7, 5'd0, 4'b0100);
      tick();
      idle();
      cap_mask = 4'd0;
      @(negedge clk);
      check("t2_count", count, 2);
      check("t2_stall_w0", out_data, 32'hA400_0001);
      tick();
      out_ready = 1'b1;
      expect_record("t2a", 32'hA400_0001, 32'h10, 32'hAC0A_0000, 32'hDEAD_BEEF);
      expect_record("t2c", 32'hA400_0003, 32'h18, 32'hAC0B_0004, 32'h0BAD_F00D);

      // Overflow: 11 captures into an 8-deep FIFO with the sink stalled.
      out_ready = 1'b0;
      do_reset();
      for (int i = 0; i < 11; i++) begin
         set_rec(32'h100 + i, 32'h3C00_0000 + i, 32'h50 + i, 32'h0, 32'h0, 5'd1, 4'b1000);
         tick();
      end
      idle();
      @(negedge clk);
      check("t3_count", count, 8);
      check("t3_drop", drop_count, 3);
      check("t3_ovf", overflow, 1);
      check("t3_stall_a", out_data, 32'hA801_0000);
      @(negedge clk);
      check("t3_stall_b", out_data, 32'hA801_0000);
      tick();
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++)
         expect_record($sformatf("t3r%0d", i), 32'hA801_0000 | i, 32'h100 + i,
                       32'h3C00_0000 + i, 32'h50 + i);

      // Full FIFO, capture coincides with the head's W3 handshake.
      out_ready = 1'b0;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         set_rec(32'h200 + i, 32'h3C00_0000 + i, 32'h50 + i, 32'h0, 32'h0, 5'd2, 4'b1000);
         tick();
      end
      idle();
      tick();
      out_ready = 1'b1;
      begin
         logic [31:0] head [3];
         head = '{32'hA802_0000, 32'h200, 32'h3C00_0000};
         for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("t4_head_w%0d", k), out_data, head[k]);
            tick();
         end
      end
      set_rec(32'h208, 32'h3C00_0008, 32'h58, 32'h0, 32'h0, 5'd2, 4'b1000);
      @(negedge clk);
      check("t4_head_last", out_last, 1);
      check("t4_head_w3", out_data, 32'h50);
      tick();
      idle();
      out_ready = 1'b0;
      @(negedge clk);
      check("t4_count", count, 8);
      check("t4_drop", drop_count, 0);
      check("t4_ovf", overflow, 0);
      tick();
      out_ready = 1'b1;
      for (int i = 1; i < 9; i++)
         expect_record($sformatf("t4r%0d", i), 32'hA802_0000 | i, 32'h200 + i,
                       32'h3C00_0000 + i, 32'h50 + i);

      // Reset after W1 of a record has been accepted.
      out_ready = 1'b0;
      do_reset();
      set_rec(32'h300, 32'hAA, 32'hBB, 32'h0, 32'h0, 5'd3, 4'b1000);
      tick();
      idle();
      tick();
      out_ready = 1'b1;
      @(negedge clk);
      check("t5_w0", out_data, 32'hA803_0000);
      tick();
      @(negedge clk);
      check("t5_w1", out_data, 32'h300);
      tick();
      @(negedge clk);
      check("t5_w2", out_data, 32'hAA);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("t5_valid", out_valid, 0);
      check("t5_count", count, 0);
      check("t5_data", out_data, 0);
      check("t5_last", out_last, 0);
      tick();
      set_rec(32'h304, 32'hCC, 32'hDD, 32'h0, 32'h0, 5'd3, 4'b1000);
      tick();
      idle();
      expect_record("t5n", 32'hA803_0000, 32'h304, 32'hCC, 32'hDD);

      // Long drop run to saturate drop_count and walk seq up to the wrap.
      out_ready = 1'b0;
      do_reset();
      set_rec(32'h40, 32'h0, 32'h7, 32'h0, 32'h0, 5'd2, 4'b1000);
      repeat (65534) tick();
      idle();
      @(negedge clk);
      check("t6_drop_a", drop_count, 16'hFFF6);
      check("t6_count_a", count, 8);
      check("t6_ovf", overflow, 1);
      tick();
      out_ready = 1'b1;
      begin
         int t;
         t = 0;
         while (count != 0 && t < 100) begin
            t++;
            @(negedge clk);
         end
      end
      check("t6_drained", count, 0);
      tick();
      out_ready = 1'b0;
      set_rec(32'h40, 32'h0, 32'h7, 32'h0, 32'h0, 5'd2, 4'b1000);
      repeat (17) tick();
      idle();
      @(negedge clk);
      check("t6_drop_sat", drop_count, 16'hFFFF);
      tick();
      set_rec(32'h40, 32'h0, 32'h7, 32'h0, 32'h0, 5'd2, 4'b1000);
      repeat (3) tick();
      idle();
      @(negedge clk);
      check("t6_drop_hold", drop_count, 16'hFFFF);
      check("t6_count_b", count, 8);
      tick();
      out_ready = 1'b1;
      expect_record("t6s0", 32'hA802_FFFE, 32'h40, 32'h0, 32'h7);
      expect_record("t6s1", 32'hA802_FFFF, 32'h40, 32'h0, 32'h7);
      expect_record("t6s2", 32'hA802_0000, 32'h40, 32'h0, 32'h7);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
